// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-file widths, counter sizing and scoreboard FSM encoding
package reg_scoreboard_pkg;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int BUSY_W = REG_AW + CNT_W;
  typedef enum logic {SB_RUN = 1'b0, SB_DRAIN = 1'b1} sb_state_e;
endpackage

// File: rtl/reg_scoreboard_sat_counter.sv
// sb_sat_counter: per-register outstanding-write counter that neither wraps up nor down
module sb_sat_counter
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full
);
  assign zero = cnt == '0;
  assign full = &cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && !zero) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side RAW/overflow scoreboard with flush drain; SB_WB_BYPASS_EN adds writeback forwarding
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_we,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [BUSY_W-1:0] busy_count,
  output logic              err_underflow
`ifdef SB_WB_BYPASS_EN
  ,
  output logic              fwd_rs1,
  output logic              fwd_rs2
`endif
);
  sb_state_e state, state_n;
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0] zero, full;
  logic hz1_raw, hz2_raw, hz1, hz2, ovf, inc_any, dec_any;
  assign cnt[0]  = '0;
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;
  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    sb_sat_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_any && rd == REG_AW'(i)),
      .dec  (dec_any && wb_rd == REG_AW'(i)),
      .cnt  (cnt[i]),
      .zero (zero[i]),
      .full (full[i])
    );
  end
  assign hz1_raw = use_rs1 && rs1 != '0 && cnt[rs1] != '0;
  assign hz2_raw = use_rs2 && rs2 != '0 && cnt[rs2] != '0;
`ifdef SB_WB_BYPASS_EN
  assign fwd_rs1 = hz1_raw && cnt[rs1] == CNT_W'(1) && wb_valid && wb_rd == rs1;
  assign fwd_rs2 = hz2_raw && cnt[rs2] == CNT_W'(1) && wb_valid && wb_rd == rs2;
  assign hz1 = hz1_raw && !fwd_rs1;
  assign hz2 = hz2_raw && !fwd_rs2;
`else
  assign hz1 = hz1_raw;
  assign hz2 = hz2_raw;
`endif
  assign ovf     = rd_we && rd != '0 && full[rd];
  assign stall   = issue_valid && (hz1 || hz2 || ovf || state != SB_RUN || flush_req);
  assign inc_any = issue_valid && !stall && rd_we && rd != '0;
  assign dec_any = wb_valid && wb_rd != '0 && !zero[wb_rd];
  always_comb begin
    flush_done = state == SB_DRAIN && busy_count == '0 && !dec_any;
    state_n    = (state == SB_RUN && flush_req) ? SB_DRAIN : flush_done ? SB_RUN : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= SB_RUN;
      busy_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_n;
      busy_count    <= busy_count + BUSY_W'(inc_any) - BUSY_W'(dec_any);
      err_underflow <= err_underflow || (wb_valid && wb_rd != '0 && zero[wb_rd]);
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus random traffic against a per-register pending-count model
module tb_reg_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, use_rs1 = 0, use_rs2 = 0, rd_we = 0, wb_valid = 0, flush_req = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0, wb_rd = 0;
  logic stall, flush_done, err_underflow;
  logic [6:0] busy_count;
  int vectors = 0, miscompares = 0;
  int m_cnt[32];
  bit m_err = 0, m_drain = 0;
  int fd_seen;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .rd_we(rd_we), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush_req(flush_req), .flush_done(flush_done),
    .busy_count(busy_count), .err_underflow(err_underflow)
  );

  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_total();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
    m_drain = 0;
  endtask

  // Called at posedge+1; checks mid-cycle, then advances the model across the next edge.
  task automatic step(bit iv, bit [4:0] a, bit ua, bit [4:0] b, bit ub,
                      bit [4:0] d, bit we, bit wv, bit [4:0] w, bit fr);
    bit s_e, fd_e, fire, dec;
    int tot;
    issue_valid = iv; rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub;
    rd = d; rd_we = we; wb_valid = wv; wb_rd = w; flush_req = fr;
    #4;
    tot  = m_total();
    s_e  = iv && ((ua && a != 0 && m_cnt[a] > 0) || (ub && b != 0 && m_cnt[b] > 0) ||
                  (we && d != 0 && m_cnt[d] == 3) || m_drain || fr);
    fd_e = m_drain && tot == 0;
    check("stall", stall, s_e);
    check("flush_done", flush_done, fd_e);
    check("busy_count", busy_count, tot);
    check("err_underflow", err_underflow, m_err);
    if (flush_done) fd_seen++;
    fire = iv && !s_e;
    dec  = wv && w != 0 && m_cnt[w] > 0;
    if (wv && w != 0 && m_cnt[w] == 0) m_err = 1;
    if (dec) m_cnt[w]--;
    if (fire && we && d != 0) m_cnt[d]++;
    if (fd_e) m_drain = 0;
    else if (fr) m_drain = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle();
    // RAW on x3, cleared by writeback
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_cleared_busy", busy_count, 0);
    // x0 never tracked
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("x0_busy", busy_count, 0);
    // saturate x5, then issue+writeback same cycle
    repeat (3) step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    check("x5_full", busy_count, 3);
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    step(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    check("inc_dec_same", busy_count, 2);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    // flush with two outstanding writes
    step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    fd_seen = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 8, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    check("flush_done_once", fd_seen, 1);
    check("resume_busy", busy_count, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    // empty flush: one DRAIN cycle
    fd_seen = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("empty_flush_once", fd_seen, 1);
    // underflow is sticky
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle();
    check("err_sticky", err_underflow, 1);
    // async reset mid-drain
    step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue_valid = 1; flush_req = 0; wb_valid = 0; rd_we = 0; use_rs1 = 0; use_rs2 = 0;
    #2 rst = 1;
    #1;
    m_reset();
    check("rst_busy", busy_count, 0);
    check("rst_err", err_underflow, 0);
    check("rst_stall", stall, 0);
    check("rst_flush_done", flush_done, 0);
    @(posedge clk);
    #1 rst = 0;
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 40) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
